// File: rtl/load_unit_if.sv
// Request, response and data-memory signals of the load engine.
// The master side is the requester together with the memory model behind it.
interface load_unit_if;
  logic        start;
  logic [2:0]  LoadTYPE;
  logic [63:0] Address;
  logic [63:0] mem_addr;
  logic        mem_read;
  logic [63:0] mem_data_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [63:0] LoadResult;
  logic [63:0] RawWord;

  modport master (
    output start, LoadTYPE, Address, mem_data_in,
    input  mem_addr, mem_read, busy, done, error, LoadResult, RawWord
  );

  modport slave (
    input  start, LoadTYPE, Address, mem_data_in,
    output mem_addr, mem_read, busy, done, error, LoadResult, RawWord
  );
endinterface

// File: rtl/load_unit.sv
// Multicycle load engine: one read strobe, fixed memory latency, then
// sign/zero extension of the low-order field of the returned doubleword.
module load_unit #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic      clk,
  input  logic      reset,
  load_unit_if.slave bus
);
  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_type;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_load_result;
  logic [XLEN-1:0]   r_raw_word;
  logic              r_mem_read;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [XLEN-1:0]   w_ext;
  logic [XLEN-1:0]   w_d;

  assign w_d = bus.mem_data_in;

  // Extend the low-order field; the address offset never selects the field.
  always_comb begin
    w_ext = '0;
    case (r_type)
      3'd1:    w_ext = w_d;
      3'd2:    w_ext = {{32{w_d[31]}}, w_d[31:0]};
      3'd3:    w_ext = {{48{w_d[15]}}, w_d[15:0]};
      3'd4:    w_ext = {{56{w_d[7]}},  w_d[7:0]};
      3'd5:    w_ext = {56'd0, w_d[7:0]};
      3'd6:    w_ext = {48'd0, w_d[15:0]};
      3'd7:    w_ext = {32'd0, w_d[31:0]};
      default: w_ext = '0;
    endcase
  end

  // Request FSM with registered outputs; done/error/mem_read are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_type        <= '0;
      r_mem_addr    <= '0;
      r_load_result <= '0;
      r_raw_word    <= '0;
      r_mem_read    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_mem_read <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mem_addr <= bus.Address;
            r_type     <= bus.LoadTYPE;
            if (bus.LoadTYPE == 3'd0) begin
              // Illegal type completes at once without touching memory.
              r_load_result <= '0;
              r_done        <= 1'b1;
              r_error       <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_mem_read <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          r_cnt   <= CNT_W'(MEM_LATENCY - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_raw_word    <= w_d;
            r_load_result <= w_ext;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_read   = r_mem_read;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.LoadResult = r_load_result;
  assign bus.RawWord    = r_raw_word;

endmodule

// File: doc/load_unit.md
# load_unit

Multicycle load engine for the datapath's memory stage, the read-side counterpart of the store merge logic. On a start pulse it captures the address and load type, issues a single-cycle read to data memory, waits a fixed memory latency, then sign- or zero-extends the low-order field of the returned doubleword into a registered 64-bit result. It also exposes the raw doubleword so the store path can merge sub-word stores without a second read.

## Interface
- MEM_LATENCY, 2, cycles from the mem_read cycle until mem_data_in is valid; legal range 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- LoadTYPE  in  3  1=ld, 2=lw, 3=lh, 4=lb, 5=lbu, 6=lhu, 7=lwu, 0=illegal.
- Address  in  64  byte address; captured on accepted start.
- mem_addr  out  64  registered address presented to memory.
- mem_read  out  1  one-cycle read strobe.
- mem_data_in  in  64  doubleword returned by memory.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle completion pulse.
- error  out  1  set with done when LoadTYPE was 0.
- LoadResult  out  64  extended load value; held until next completion.
- RawWord  out  64  unmodified doubleword from the last completed read.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on start=1, capture Address into mem_addr and LoadTYPE into a type register.
  - LoadTYPE≠0: go to REQ.
  - LoadTYPE=0: go to DONE with the error flag armed. No memory access.
- REQ: mem_read=1 for exactly this cycle. Load the wait counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 0, capture mem_data_in into RawWord and the extended value into LoadResult on that edge, then go to DONE.
- DONE: done=1 for one cycle, error=1 if armed. Go to IDLE.
- Extraction always uses the low-order field, bits [63:0] / [31:0] / [15:0] / [7:0]. Address[2:0] does not select the field; this matches the store path's low-order merge.
  - ld passes all 64 bits.
  - lw/lh/lb replicate bit 31/15/7 into the upper bits.
  - lwu/lhu/lbu fill the upper bits with zeros.
- Illegal type: LoadResult=0 and RawWord unchanged.
- start outside IDLE is ignored; it is not queued.
- Address and LoadTYPE changes after capture have no effect.

## Timing
- Reset (at the edge with reset=1) sets: state=IDLE, counter=0, mem_read=0, mem_addr=0, busy=0, done=0, error=0, LoadResult=0, RawWord=0.
- Reset mid-operation aborts the request. No done is produced, and outputs take reset values on the following cycle.
- start accepted at edge t:
  - REQ during cycle t+1, with mem_read=1 and mem_addr valid.
  - Memory data sampled at the edge ending cycle t+1+MEM_LATENCY.
  - done=1 during cycle t+2+MEM_LATENCY, with LoadResult/RawWord valid.
  - Total latency is MEM_LATENCY+2 cycles. The next start can be accepted in the cycle after done.
- Illegal type: done=1 and error=1 during cycle t+1. mem_read stays 0.
- busy=1 during REQ and WAIT, and 0 in IDLE and DONE.
- mem_addr holds its value until the next accepted start.
- error is a pulse coincident with done.
- All outputs are registered. No combinational path from start to any output.

## Test plan
- Reset: hold reset for 2 cycles after arbitrary activity -> all outputs 0, state IDLE. Then start with lb at mem_data_in=0x0123456789ABCDEF, MEM_LATENCY=2 -> done exactly 4 cycles after start, LoadResult=0xFFFFFFFFFFFFFFEF.
- Extension sweep, mem_data_in=0x0123456789ABCDEF:
  - ld -> 0x0123456789ABCDEF
  - lw -> 0xFFFFFFFF89ABCDEF
  - lwu -> 0x0000000089ABCDEF
  - lh -> 0xFFFFFFFFFFFFCDEF
  - lhu -> 0x000000000000CDEF
  - lbu -> 0x00000000000000EF
  - RawWord = input word in every case.
- Positive sign cases, mem_data_in=0x7FFF7FFF7FFF7F70: lb -> 0x70, lh -> 0x7F70, lw -> 0x7FFF7F70, all with zero upper bits.
- Handshake: start pulsed again during WAIT -> ignored; exactly one mem_read and one done. Vary MEM_LATENCY over 1, 2, 15 -> done at start+3, +4, +17.
- Illegal type: LoadTYPE=0, Address=0x40 -> done and error high one cycle after start, mem_read never asserted, LoadResult=0, RawWord and mem_addr behave per the rules above.
- Abort: assert reset in the cycle after REQ -> no done pulse, busy=0 and LoadResult=0 on the next cycle. A fresh ld then completes normally.
